aes_iter_enc: RTL
=================

AES_ITER_ENC -- requirements
Module: aes_iter_enc

Interface
REQ-001 The block SHALL have parameter BLOCK_LENGTH, default 128, meaning data block width; only 128 is legal, and elaboration SHALL fail otherwise.
REQ-002 The block SHALL have parameter KEY_WIDTH, default 256, meaning key port width; only 256 is legal.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request to start one encryption.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 IN  input  BLOCK_LENGTH  plaintext, FIPS-197 byte 0 at [127:120].
REQ-008 KEY  input  KEY_WIDTH  cipher key, MSB-aligned; AES-128 uses KEY[255:128], AES-256 uses KEY[255:0].
REQ-009 key_256  input  1  1 selects AES-256 (14 rounds), 0 selects AES-128 (10 rounds).
REQ-010 out_valid  output  1  OUT holds a completed ciphertext.
REQ-011 out_ready  input  1  consumer accepts OUT this cycle.
REQ-012 OUT  output  BLOCK_LENGTH  ciphertext, same byte order as IN.

Function
REQ-013 The block SHALL be iterative, computing one AES round per cycle with on-the-fly round-key expansion and no precomputed key schedule storage.
REQ-014 The FSM SHALL have states IDLE, ROUND and DONE.
REQ-015 A request is accepted on an edge where in_valid and in_ready are both 1; IN, KEY and key_256 are sampled only at that edge, and later changes SHALL be ignored.
REQ-016 At acceptance the state register SHALL load IN XOR round key 0, the round counter SHALL load 1, and the FSM SHALL enter ROUND.
REQ-017 In ROUND each edge SHALL apply round r (SubBytes, ShiftRows, MixColumns, AddRoundKey), omitting MixColumns when r equals Nr, and then increment r.
REQ-018 After round Nr the FSM SHALL enter DONE with out_valid=1, where Nr is 10 for AES-128 and 14 for AES-256.
REQ-019 Latency from the accept edge to the out_valid rising edge SHALL be exactly Nr edges: 10 or 14.
REQ-020 in_ready SHALL be 1 in IDLE, 1 in DONE only while out_ready=1, and 0 in ROUND.
REQ-021 In DONE, OUT and out_valid SHALL hold stable until out_ready=1.
REQ-022 On a DONE edge with out_ready=1, the FSM SHALL enter ROUND if a new request is accepted on the same edge, otherwise IDLE; back-to-back throughput is one block per Nr+1 cycles.
REQ-023 OUT SHALL be 0 whenever out_valid=0.
REQ-024 in_valid asserted while in_ready=0 SHALL NOT be accepted or queued.

Reset
REQ-025 Asserting rst low at any time, including mid-round, SHALL asynchronously force IDLE, counter 0, state and key registers 0, out_valid 0 and OUT 0; the in-flight block SHALL be discarded.
REQ-026 in_ready SHALL be 1 during reset; the first accept can occur on the first edge after rst is released.

Configuration
REQ-027 With macro AES_KEY256_EN defined, both key lengths SHALL be supported as described above.
REQ-028 Without AES_KEY256_EN, key_256 SHALL be ignored (treated as 0), only AES-128 logic and registers SHALL be built, KEY[127:0] SHALL be unused, and Nr SHALL be fixed at 10.

Structure
REQ-029 A shared package aes_pkg SHALL hold the S-box table, the Rcon table, the FSM state enum, and the constants NR_128=10 and NR_256=14.
REQ-030 A combinational sub-module aes_round SHALL implement one round, with inputs state, round key and a final flag, and an output next state.

Verification
REQ-031 AES-128 (FIPS-197 C.1): IN=00112233445566778899aabbccddeeff, KEY[255:128]=000102030405060708090a0b0c0d0e0f, key_256=0 -> OUT=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 10 edges after accept.
REQ-032 AES-256 (FIPS-197 C.3): same IN, KEY=000102...1e1f, key_256=1 -> OUT=8ea2b7ca516745bfeafc49904b496089 after 14 edges; without AES_KEY256_EN -> the AES-128 result for KEY[255:128].
REQ-033 All-zero IN and key, key_256=0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e; hold out_ready=0 for 5 cycles -> OUT and out_valid stable and in_ready=0.
REQ-034 Back-to-back: in_valid held with the C.1 vector then the zero vector, out_ready=1 -> second accept on the same edge as the first output handshake, and both ciphertexts correct.
REQ-035 Drive rst low at round 5 of an AES-128 job -> outputs 0 immediately; a new C.1 request after release -> correct result in 10 edges.
REQ-036 Toggle IN, KEY and key_256 during ROUND -> result equals the values sampled at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: S-box and Rcon tables, FSM state type and round counts shared by the AES encryptor.
// Pure constants and combinational helpers, no state.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;

  // Written in FIPS-197 order, so the entry for byte b sits at element 255-b (= ~b).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Element i is Rcon[i]; only 1..10 are ever used.
  localparam logic [15:0][7:0] RCON = 128'h0000000000361b804020100804020100;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Next four schedule words: prev is the round key Nk words back, last the most recent word.
  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [31:0] last,
                                            input logic rot, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = rot ? (sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h0}) : sub_word(last);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round (SubBytes, ShiftRows, MixColumns unless final, AddRoundKey).
// Zero latency; the caller registers next_state.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [127:0] shifted;
  logic [127:0] mixed;

  always_comb begin
    shifted = '0;
    mixed   = '0;
    // Byte (row r, column c) is the substituted byte taken from column c+r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
    end
    next_state = (final_round ? shifted : mixed) ^ round_key;
  end

endmodule

// File: rtl/aes_iter_enc.sv
// aes_iter_enc: iterative AES encryptor, one round per edge, Nr=10/14 edges accept-to-out_valid.
// OUT held until out_ready, in_ready low while busy; AES_KEY256_EN adds AES-256 (default AES-128 only).
module aes_iter_enc
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int KEY_WIDTH    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [KEY_WIDTH-1:0]    KEY,
  input  logic                    key_256,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT
);

  if (BLOCK_LENGTH != 128 || KEY_WIDTH != 256) begin : g_bad_param
    $error("aes_iter_enc: BLOCK_LENGTH must be 128 and KEY_WIDTH must be 256");
  end

  state_t       st;
  logic [3:0]   rnd;
  logic [127:0] state_q;
  logic [127:0] round_key;
  logic [127:0] next_state;
  logic [3:0]   nr;
  logic         accept;

`ifdef AES_KEY256_EN
  logic [255:0] key_q;
  logic [255:0] key_next;
  logic         is256;
  logic [127:0] rk_128;

  assign nr = is256 ? NR_256 : NR_128;
  // AES-128 keeps rk[r-1] in the upper half and derives rk[r] in the same cycle.
  assign rk_128 = key_step(key_q[255:128], key_q[159:128], 1'b1, RCON[rnd]);
  // AES-256 keeps {rk[r-1], rk[r]} and prepares rk[r+1] for the next edge.
  assign round_key = is256 ? key_q[127:0] : rk_128;
  assign key_next  = is256 ? {key_q[127:0],
                              key_step(key_q[255:128], key_q[31:0], rnd[0], RCON[(rnd + 4'd1) >> 1])}
                           : {rk_128, 128'h0};
`else
  logic [127:0] key_q;
  logic [127:0] key_next;
  logic         unused_key;

  assign nr         = NR_128;
  assign round_key  = key_step(key_q, key_q[31:0], 1'b1, RCON[rnd]);
  assign key_next   = round_key;
  assign unused_key = ^{KEY[127:0], key_256};
`endif

  aes_round u_round (
    .state      (state_q),
    .round_key  (round_key),
    .final_round(rnd == nr),
    .next_state (next_state)
  );

  assign in_ready = (st == IDLE) || (st == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign OUT      = out_valid ? state_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      rnd       <= '0;
      state_q   <= '0;
      key_q     <= '0;
      out_valid <= 1'b0;
`ifdef AES_KEY256_EN
      is256     <= 1'b0;
`endif
    end else if (accept) begin
      st        <= ROUND;
      rnd       <= 4'd1;
      state_q   <= IN ^ KEY[255:128];
      out_valid <= 1'b0;
`ifdef AES_KEY256_EN
      key_q     <= KEY;
      is256     <= key_256;
`else
      key_q     <= KEY[255:128];
`endif
    end else begin
      case (st)
        ROUND: begin
          state_q <= next_state;
          key_q   <= key_next;
          rnd     <= rnd + 4'd1;
          if (rnd == nr) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            rnd       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
